// File: rtl/obi_wb_data_bridge.sv
// OBI data port to Wishbone B4 classic bridge: one transaction outstanding, registered bus outputs.
// Grant is combinational in IDLE/RESP; rvalid follows the Wishbone termination by one cycle.
module obi_wb_data_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    obi_req_i,
  output logic                    obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
  input  logic                    obi_we_i,
  input  logic [DATA_WIDTH/8-1:0] obi_be_i,
  input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
  output logic                    obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]   obi_rdata_o,
  output logic                    obi_err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  // A disabled timeout still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    cyc_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [BE_W-1:0]         sel_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic                    rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic                    timeout_hit;
  logic                    term_d;
  logic                    err_d;
  logic [DATA_WIDTH-1:0]   rdata_d;

  assign obi_gnt_o = obi_req_i & ((state_q == IDLE) | (state_q == RESP));

  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES != 0) begin
      timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    end
    term_d  = wb_ack_i | wb_err_i | timeout_hit;
    // Anything other than a clean ack (bus error or timeout) is an error response.
    err_d   = wb_err_i | ~wb_ack_i;
    rdata_d = '0;
    if (wb_ack_i && !wb_err_i && !we_q) begin
      rdata_d = wb_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (obi_gnt_o) begin
            state_q <= BUS;
            cnt_q   <= '0;
            cyc_q   <= 1'b1;
            we_q    <= obi_we_i;
            adr_q   <= {obi_addr_i[ADDR_WIDTH-1:2], 2'b00};
            sel_q   <= obi_be_i;
            dat_q   <= obi_wdata_i;
          end else begin
            state_q <= IDLE;
          end
        end
        BUS: begin
          if (term_d) begin
            state_q  <= RESP;
            cyc_q    <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            // Saturate so a disabled timeout can never wrap into a false hit.
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = sel_q;
  assign wb_dat_o     = dat_q;
  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;
  assign obi_err_o    = err_q;

endmodule
